alu_multicycle: RTL and testbench
=================================

// Module: alu_multicycle
// PURPOSE
// - Parametrised, clocked successor to the CPU's one-hot combinational ALU. Sits between the AC/DR register pair and the AC write-back path.
// - Binary opcode replaces one-hot strobes. Single-cycle logic/add ops; iterative signed MUL and unsigned DIV (shift-add / restoring).
// - Valid/ready handshake on both sides, with registered result and status flags.
// PARAMETERS
// - WIDTH  19  operand/result width in bits (>=4)
// PORTS
// - clk        in   1      single clock; all state on rising edge
// - rst        in   1      synchronous, active-high reset
// - in_valid   in   1      op/operands valid
// - in_ready   out  1      block can accept an op this cycle
// - op         in   4      opcode (see BEHAVIOUR)
// - ac         in   WIDTH  operand A (accumulator)
// - dr         in   WIDTH  operand B (data register)
// - out_valid  out  1      result/flags valid; held until out_ready
// - out_ready  in   1      consumer takes result
// - result     out  WIDTH  registered result
// - flag_ovf   out  1      signed overflow
// - flag_zero  out  1      result == 0
// - flag_neg   out  1      result[WIDTH-1]
// - flag_dz    out  1      divide (or remainder) by zero
// - flag_ill   out  1      illegal/reserved opcode
// BEHAVIOUR
// - Reset: state IDLE; out_valid=0; result=0; all flags=0; in_ready=1 the cycle after rst deasserts. rst mid-MUL/DIV aborts the op; no output is produced.
// - FSM: IDLE -> (accept MUL, or DIV with dr!=0) -> ITER -> DONE; IDLE -> (accept any other op) -> DONE; DONE -> IDLE on out_ready.
// - in_ready = (state==IDLE) | (state==DONE & out_ready). An accept in DONE drains and accepts in the same cycle; an accepted single-cycle op re-enters DONE.
// - Accept = in_valid & in_ready. Operands and op are latched on accept; ac/dr may change afterwards.
// - Latency from accept at cycle N: single-cycle ops -> out_valid at N+1. MUL/DIV -> out_valid at N+1+WIDTH. The ITER counter is $clog2(WIDTH+1) bits wide.
// - Opcodes:
//   - 0 ADD a+b; 1 SUB a-b; 2 MUL; 3 DIV; 4 AND; 5 OR; 6 XOR; 7 NOT ~b
//   - 8 INC a+1; 9 DEC a-1; 10 TNF b; 11 REM; 12-15 reserved
// - ADD/SUB/INC/DEC: two's complement, wraps modulo 2^WIDTH. flag_ovf = signed overflow (e.g. INC of max positive -> min negative, ovf=1).
// - MUL: signed. Operate on magnitudes, then negate the 2*WIDTH product if the signs differ. result = product[WIDTH-1:0]. flag_ovf=1 unless product[2W-1:W-1] is all 0s or all 1s.
// - DIV: unsigned restoring division, quotient to result.
// - Divide by zero: dr==0 skips ITER and gives out_valid at N+1 with result=0, flag_dz=1.
// - Logic/TNF/NOT: flag_ovf=0.
// - Reserved op (and REM when disabled): result=0, flag_ill=1, latency 1.
// - flag_zero/flag_neg are always derived from the final result. result/flags are stable while out_valid=1.
// CONFIGURATION
// - ALU_REM_EN defined: op 11 runs the DIV datapath and returns the remainder, with the same latency and divide-by-zero rules.
// - ALU_REM_EN undefined: op 11 is illegal (result=0, flag_ill=1). The remainder register is not kept.
// STRUCTURE
// - Package alu_pkg:
//   - op_e opcode enum (values above)
//   - state_e {IDLE, ITER, DONE}
//   - flag struct {ovf, zero, neg, dz, ill}
// - Sub-module alu_iter_muldiv: shared shift register / accumulator for MUL and DIV.
//   - Ports: start, is_div, a, b, done, lo, hi.
//   - One iteration per cycle, WIDTH iterations.
// - Top level holds the FSM, handshake, single-cycle ops and flag logic.
// TESTING (WIDTH=19)
// - Reset, then ADD 0x3FFFF+1 -> out_valid next cycle, result 0x40000, ovf=1, neg=1.
// - MUL 300*2000 -> out_valid 20 cycles after accept, result 75712, ovf=1.
// - MUL -5*7 -> result 0x7FFDD (-35), ovf=0.
// - DIV 100/7 -> result 14; DIV by 0 -> result 0, dz=1, latency 1.
// - REM 100/7 -> 2 with ALU_REM_EN; flag_ill=1 without it.
// - Backpressure: out_ready=0 for 5 cycles holds result/flags and keeps in_ready=0.
//   - Then out_ready=1 together with in_valid=1 (AND) accepts in the same cycle.
// - Assert rst during MUL ITER -> no out_valid; next op (op 12) -> flag_ill=1, result 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode encoding, FSM states and
// the status flag bundle. The optional remainder op is enabled by ALU_REM_EN.
package alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_NOT = 4'd7,
    OP_INC = 4'd8,
    OP_DEC = 4'd9,
    OP_TNF = 4'd10,
    OP_REM = 4'd11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_e;

  typedef struct packed {
    logic ovf;
    logic zero;
    logic neg;
    logic dz;
    logic ill;
  } flag_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative engine shared by MUL (shift-add on magnitudes) and DIV
// (restoring, unsigned). One step per cycle, WIDTH steps in total; the
// first step is taken on the start cycle itself so the product/quotient is
// ready WIDTH cycles after start. Used with or without ALU_REM_EN; hi holds
// the remainder after a divide.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic             div_r;
  logic [WIDTH-1:0] b_r;

  // One iteration: returns the next {hi, lo}.
  // MUL: hi accumulates the multiplicand when lo[0] is set, then the
  //      whole {carry, hi, lo} shifts right.
  // DIV: shift the next dividend bit into the partial remainder and keep
  //      the subtraction only if it does not borrow.
  function automatic logic [2*WIDTH-1:0] step(input logic div,
                                                input logic [WIDTH-1:0] h,
                                                input logic [WIDTH-1:0] l,
                                                input logic [WIDTH-1:0] d);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] sh;
    logic [WIDTH:0] diff;
    if (div) begin
      sh   = {h, l[WIDTH-1]};
      diff = sh - {1'b0, d};
      if (diff[WIDTH]) return {sh[WIDTH-1:0], l[WIDTH-2:0], 1'b0};
      else             return {diff[WIDTH-1:0], l[WIDTH-2:0], 1'b1};
    end else begin
      sum = {1'b0, h} + {1'b0, (l[0] ? d : {WIDTH{1'b0}})};
      return {sum, l[WIDTH-1:1]};
    end
  endfunction

  assign done = busy && (cnt == '0);

  // Iteration control: count the remaining steps, drop busy once done is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CNT_W'(WIDTH - 1);
    end else if (busy) begin
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - CNT_W'(1);
    end
  end

  // Shift/accumulate datapath; operands are captured on start.
  always_ff @(posedge clk) begin
    if (start) begin
      {hi, lo} <= step(is_div, {WIDTH{1'b0}}, a, b);
      div_r    <= is_div;
      b_r      <= b;
    end else if (busy && (cnt != '0)) begin
      {hi, lo} <= step(div_r, hi, lo, b_r);
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Clocked ALU between the AC/DR pair and AC write-back. Single-cycle
// arithmetic/logic ops plus iterative signed MUL and unsigned DIV, with a
// valid/ready handshake on both sides and registered result/flags.
// Define ALU_REM_EN to enable op 11 (REM); otherwise op 11 is illegal.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] ac,
  input  logic [WIDTH-1:0] dr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_ovf,
  output logic             flag_zero,
  output logic             flag_neg,
  output logic             flag_dz,
  output logic             flag_ill
);

  localparam logic signed [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] ONE_S   = WIDTH'(1);

  state_e state;
  flag_t  flags;

  logic signed [WIDTH-1:0] a_s, b_s, sum_ab, diff_ab, inc_a, dec_a;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_ovf, sc_dz, sc_ill;
  logic               iter_go, go_div, accept;
  logic [WIDTH-1:0]   it_a, it_b, it_lo, it_hi, div_res, fin_res;
  logic               it_done, fin_ovf;
  logic               neg_r, div_r;
  logic [2*WIDTH-1:0] prod_u, prod_s;
`ifdef ALU_REM_EN
  logic               rem_r;
`endif

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] x, y, s);
    return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] x, y, d);
    return (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]);
  endfunction

  // Magnitude of a signed value; the most negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    r = x[WIDTH-1] ? -x : x;
    return r;
  endfunction

  // Product fits the result only if its top WIDTH+1 bits are a pure sign run.
  function automatic logic mul_ovf(input logic [2*WIDTH-1:0] p);
    return !((&p[2*WIDTH-1:WIDTH-1]) || !(|p[2*WIDTH-1:WIDTH-1]));
  endfunction

  function automatic flag_t mk_flags(input logic [WIDTH-1:0] r,
                                     input logic ovf, dz, ill);
    flag_t f;
    f.ovf  = ovf;
    f.zero = (r == '0);
    f.neg  = r[WIDTH-1];
    f.dz   = dz;
    f.ill  = ill;
    return f;
  endfunction

  assign a_s     = ac;
  assign b_s     = dr;
  assign sum_ab  = a_s + b_s;
  assign diff_ab = a_s - b_s;
  assign inc_a   = a_s + ONE_S;
  assign dec_a   = a_s - ONE_S;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);

  assign flag_ovf  = flags.ovf;
  assign flag_zero = flags.zero;
  assign flag_neg  = flags.neg;
  assign flag_dz   = flags.dz;
  assign flag_ill  = flags.ill;

  // Decode: single-cycle results, or a request to start the iterative engine.
  always_comb begin
    sc_res  = '0;
    sc_ovf  = 1'b0;
    sc_dz   = 1'b0;
    sc_ill  = 1'b0;
    iter_go = 1'b0;
    go_div  = 1'b1;
    case (op)
      OP_ADD: begin sc_res = sum_ab;  sc_ovf = add_ovf(a_s, b_s, sum_ab);  end
      OP_SUB: begin sc_res = diff_ab; sc_ovf = sub_ovf(a_s, b_s, diff_ab); end
      OP_MUL: begin iter_go = 1'b1; go_div = 1'b0; end
      OP_DIV: begin
        if (dr == '0) sc_dz   = 1'b1;
        else          iter_go = 1'b1;
      end
      OP_AND: sc_res = ac & dr;
      OP_OR:  sc_res = ac | dr;
      OP_XOR: sc_res = ac ^ dr;
      OP_NOT: sc_res = ~dr;
      OP_INC: begin sc_res = inc_a; sc_ovf = (a_s == MAX_POS); end
      OP_DEC: begin sc_res = dec_a; sc_ovf = (a_s == MIN_NEG); end
      OP_TNF: sc_res = dr;
`ifdef ALU_REM_EN
      OP_REM: begin
        if (dr == '0) sc_dz   = 1'b1;
        else          iter_go = 1'b1;
      end
`endif
      default: sc_ill = 1'b1;
    endcase
  end

  // MUL runs on magnitudes; DIV/REM take the raw unsigned operands.
  assign it_a = go_div ? ac : mag(a_s);
  assign it_b = go_div ? dr : mag(b_s);

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && iter_go),
    .is_div (go_div),
    .a      (it_a),
    .b      (it_b),
    .done   (it_done),
    .lo     (it_lo),
    .hi     (it_hi)
  );

  assign prod_u = {it_hi, it_lo};
  assign prod_s = neg_r ? -prod_u : prod_u;

`ifdef ALU_REM_EN
  assign div_res = rem_r ? it_hi : it_lo;
`else
  assign div_res = it_lo;
`endif

  assign fin_res = div_r ? div_res : prod_s[WIDTH-1:0];
  assign fin_ovf = div_r ? 1'b0 : mul_ovf(prod_s);

  // Control FSM with registered result/flags; DONE can drain and accept at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      result <= '0;
      flags  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (iter_go) begin
              state <= ITER;
            end else begin
              state  <= DONE;
              result <= sc_res;
              flags  <= mk_flags(sc_res, sc_ovf, sc_dz, sc_ill);
            end
          end else if ((state == DONE) && out_ready) begin
            state <= IDLE;
          end
        end
        ITER: begin
          if (it_done) begin
            state  <= DONE;
            result <= fin_res;
            flags  <= mk_flags(fin_res, fin_ovf, 1'b0, 1'b0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Attributes of the op in flight, captured at accept so ac/dr may change.
  always_ff @(posedge clk) begin
    if (accept) begin
      neg_r <= ac[WIDTH-1] ^ dr[WIDTH-1];
      div_r <= go_div;
`ifdef ALU_REM_EN
      rem_r <= (op == OP_REM);
`endif
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=19). A plain-arithmetic
// reference model predicts each accepted op; one compare process checks
// out_valid timing, result and flags every cycle. Honours ALU_REM_EN.
module tb_alu_multicycle;

  localparam int W = 19;
  localparam longint MAXP = (longint'(1) << (W - 1)) - 1;
  localparam longint MINN = -(longint'(1) << (W - 1));

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready;
  logic         in_ready, out_valid;
  logic [3:0]   op;
  logic [W-1:0] ac, dr, result;
  logic         flag_ovf, flag_zero, flag_neg, flag_dz, flag_ill;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [W-1:0] res;
    logic ovf, zero, neg, dz, ill;
    int   extra;
    int   acc;
    int   due;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   first_seen = -1;
  logic [W-1:0] last_res;
  logic [4:0]   last_flags;
  int   last_lat;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .ac        (ac),
    .dr        (dr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_ovf  (flag_ovf),
    .flag_zero (flag_zero),
    .flag_neg  (flag_neg),
    .flag_dz   (flag_dz),
    .flag_ill  (flag_ill)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic longint sx(input logic [W-1:0] v);
    longint r;
    r = longint'(v);
    if (v[W-1]) r = r - (longint'(1) << W);
    return r;
  endfunction

  // Reference: exact integer arithmetic, then wrap to W bits.
  function automatic exp_t model(input int o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint full, sa, sb;
    sa = sx(a); sb = sx(b); full = 0;
    e.ovf = 0; e.dz = 0; e.ill = 0; e.extra = 0; e.acc = 0; e.due = 0;
    case (o)
      0: full = sa + sb;
      1: full = sa - sb;
      2: begin full = sa * sb; e.extra = W; end
      3: begin
        if (b == 0) e.dz = 1;
        else begin full = longint'(a) / longint'(b); e.extra = W; end
      end
      4: full = longint'(a & b);
      5: full = longint'(a | b);
      6: full = longint'(a ^ b);
      7: full = longint'(~b);
      8: full = sa + 1;
      9: full = sa - 1;
      10: full = longint'(b);
      11: begin
`ifdef ALU_REM_EN
        if (b == 0) e.dz = 1;
        else begin full = longint'(a) % longint'(b); e.extra = W; end
`else
        e.ill = 1;
`endif
      end
      default: e.ill = 1;
    endcase
    if (o == 0 || o == 1 || o == 2 || o == 8 || o == 9)
      e.ovf = (full > MAXP) || (full < MINN);
    e.res  = full[W-1:0];
    e.zero = (e.res == 0);
    e.neg  = e.res[W-1];
    return e;
  endfunction

  // Compare process: timing, result and flags against the model queue.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (exp_q.size() == 0) begin
        chk("idle_valid", out_valid, 0);
      end else begin
        cur = exp_q[0];
        if (cyc < cur.due) begin
          chk("early_valid", out_valid, 0);
        end else if (!out_valid) begin
          chk("late_valid", 0, 1);
          void'(exp_q.pop_front());
          first_seen = -1;
        end else begin
          if (first_seen < 0) first_seen = cyc;
          chk("result", result, cur.res);
          chk("flags", {flag_ovf, flag_zero, flag_neg, flag_dz, flag_ill},
                       {cur.ovf, cur.zero, cur.neg, cur.dz, cur.ill});
          if (out_ready) begin
            last_res   = result;
            last_flags = {flag_ovf, flag_zero, flag_neg, flag_dz, flag_ill};
            last_lat   = first_seen - cur.acc + 1;
            void'(exp_q.pop_front());
            first_seen = -1;
          end
        end
      end
    end
  end

  // Present one op from a negedge, hold until accepted, return at a negedge.
  task automatic send(input int o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    bit ok;
    ok = 0;
    in_valid = 1'b1; op = 4'(o); ac = a; dr = b;
    #1;
    for (int k = 0; k < 100 && !ok; k++) begin
      if (in_ready) begin
        e = model(o, a, b);
        e.acc = cyc + 1;
        e.due = e.acc + e.extra;
        exp_q.push_back(e);
        ok = 1;
      end else begin
        @(negedge clk); #1;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    ac = W'($urandom);
    dr = W'($urandom);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk); #3;
      if (exp_q.size() == 0) ok = 1;
    end
    if (!ok) begin chk("drain_timeout", 0, 1); exp_q.delete(); end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = '0; ac = '0; dr = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {flag_ovf, flag_zero, flag_neg, flag_dz, flag_ill}, 5'b00000);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);

    // ADD wrap into the sign bit
    send(0, 19'h3FFFF, 19'h00001); wait_idle();
    chk("add_res", last_res, 19'h40000);
    chk("add_flags", last_flags, 5'b10100);
    chk("add_lat", last_lat, 1);

    // MUL with overflow, latency WIDTH+1
    send(2, 19'd300, 19'd2000); wait_idle();
    chk("mul_res", last_res, 19'd75712);
    chk("mul_flags", last_flags, 5'b10000);
    chk("mul_lat", last_lat, 20);

    // MUL with mixed signs
    send(2, 19'h7FFFB, 19'd7); wait_idle();
    chk("muls_res", last_res, 19'h7FFDD);
    chk("muls_flags", last_flags, 5'b00100);

    // DIV and divide by zero
    send(3, 19'd100, 19'd7); wait_idle();
    chk("div_res", last_res, 19'd14);
    chk("div_lat", last_lat, 20);
    send(3, 19'd100, 19'd0); wait_idle();
    chk("dz_res", last_res, 19'd0);
    chk("dz_flags", last_flags, 5'b01010);
    chk("dz_lat", last_lat, 1);

    // REM: remainder when enabled, illegal otherwise
    send(11, 19'd100, 19'd7); wait_idle();
`ifdef ALU_REM_EN
    chk("rem_res", last_res, 19'd2);
    chk("rem_flags", last_flags, 5'b00000);
    chk("rem_lat", last_lat, 20);
`else
    chk("rem_res", last_res, 19'd0);
    chk("rem_flags", last_flags, 5'b01001);
    chk("rem_lat", last_lat, 1);
`endif

    // Back-to-back directed vectors, checked by the model
    send(1, 19'h00005, 19'h00007);
    send(1, 19'h40000, 19'h00001);
    send(2, 19'h40000, 19'h40000);
    send(3, 19'h7FFFF, 19'h00003);
    send(5, 19'h0F00F, 19'h00FF0);
    send(7, 19'h00000, 19'h12345);
    send(8, 19'h3FFFF, 19'h00000);
    send(9, 19'h40000, 19'h00000);
    send(8, 19'h7FFFF, 19'h00000);
    send(10, 19'h00000, 19'h55555);
    send(15, 19'h11111, 19'h22222);
    send(11, 19'd50, 19'd0);
    wait_idle();

    // Backpressure: result held, no accept while out_ready is low
    out_ready = 1'b0;
    send(6, 19'h12345, 19'h0F0F0);
    for (int k = 0; k < 5; k++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_hold", result, 19'h1D3B5);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(4, 19'h0F0F0, 19'h00FF0); wait_idle();
    chk("bp_and_res", last_res, 19'h000F0);
    chk("bp_and_lat", last_lat, 1);

    // Reset in the middle of a MUL aborts it
    send(2, 19'd3, 19'd4);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    first_seen = -1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (W + 3) @(negedge clk);
    send(12, 19'd5, 19'd6); wait_idle();
    chk("post_rst_ill_res", last_res, 19'd0);
    chk("post_rst_ill_flags", last_flags, 5'b01001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
